// File: rtl/mips_mc_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: FSM states, ALU
// operation codes (also used by the ALU), opcode/funct values, datapath mux
// encodings and the per-state Moore control word.
package mips_mc_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_MEM_ADDR,
        ST_MEM_RD,
        ST_MEM_WB,
        ST_MEM_WR,
        ST_R_EXEC,
        ST_R_WB,
        ST_I_EXEC,
        ST_I_WB,
        ST_BRANCH,
        ST_JUMP,
        ST_TRAP
    } state_t;

    // ALU operation codes
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_SLT  = 3'b100;
    localparam logic [2:0] ALU_SHR2 = 3'b101;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    // R-type funct codes (IR[5:0])
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SHR2 = 6'h02;

    // ALU B-operand mux
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // PC source mux
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Which kind of ALU operation the current state asks for
    typedef enum logic [1:0] {
        ACLS_ADD,
        ACLS_SUB,
        ACLS_FUNCT
    } alu_class_t;

    // Registered per-state control word; fetch/branch are qualified later
    // by mem_ready/zero, which are not known until the cycle itself.
    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       fetch;
        logic       pc_write;
        logic       branch;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
    } moore_t;

    function automatic moore_t moore_outputs(input state_t s);
        moore_t m;
        m = '0;
        case (s)
            ST_FETCH: begin
                m.mem_read  = 1'b1;
                m.fetch     = 1'b1;
                m.alu_src_b = SRCB_FOUR;
                m.pc_src    = PCSRC_ALU;
            end
            ST_DECODE:   m.alu_src_b = SRCB_IMM_SH;
            ST_MEM_ADDR: begin
                m.alu_src_a = 1'b1;
                m.alu_src_b = SRCB_IMM;
            end
            ST_MEM_RD: begin
                m.mem_read = 1'b1;
                m.iord     = 1'b1;
            end
            ST_MEM_WB: begin
                m.reg_write  = 1'b1;
                m.mem_to_reg = 1'b1;
            end
            ST_MEM_WR: begin
                m.mem_write = 1'b1;
                m.iord      = 1'b1;
            end
            ST_R_EXEC: begin
                m.alu_src_a = 1'b1;
                m.alu_src_b = SRCB_REG;
            end
            ST_R_WB: begin
                m.reg_write = 1'b1;
                m.reg_dst   = 1'b1;
            end
            ST_I_EXEC: begin
                m.alu_src_a = 1'b1;
                m.alu_src_b = SRCB_IMM;
            end
            ST_I_WB:     m.reg_write = 1'b1;
            ST_BRANCH: begin
                m.alu_src_a = 1'b1;
                m.alu_src_b = SRCB_REG;
                m.pc_src    = PCSRC_ALUOUT;
                m.branch    = 1'b1;
            end
            ST_JUMP: begin
                m.pc_write = 1'b1;
                m.pc_src   = PCSRC_JUMP;
            end
            default: m = '0;
        endcase
        return m;
    endfunction

    function automatic alu_class_t state_alu_class(input state_t s);
        alu_class_t c;
        c = ACLS_ADD;
        if (s == ST_R_EXEC) begin
            c = ACLS_FUNCT;
        end else if (s == ST_BRANCH) begin
            c = ACLS_SUB;
        end
        return c;
    endfunction

endpackage

// File: rtl/mips_mc_alu_dec.sv
// ALU operation decoder: maps the state's operation class and the R-type
// funct field onto the 3-bit ALU code, flagging unsupported funct values.
module mips_mc_alu_dec
    import mips_mc_pkg::*;
(
    input  alu_class_t  alu_cls,
    input  logic [5:0]  funct,
    output logic [2:0]  alu_op,
    output logic        funct_illegal
);

    // Unsupported funct falls back to ADD so the ALU never sees a junk code
    always_comb begin
        alu_op        = ALU_ADD;
        funct_illegal = 1'b0;
        case (alu_cls)
            ACLS_SUB:   alu_op = ALU_SUB;
            ACLS_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_SLT:  alu_op = ALU_SLT;
                    FN_SHR2: alu_op = ALU_SHR2;
                    default: funct_illegal = 1'b1;
                endcase
            end
            default:    alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_mc_controller.sv
// Multi-cycle MIPS control FSM. Control word is registered from the next
// state; only ir_write/pc_write (qualified by mem_ready in FETCH) and
// pc_write_cond (qualified by zero in BRANCH) plus the funct-driven alu_op
// are combinational.
// Optional feature: define MC_ILLEGAL_TRAP_EN to send illegal opcode/funct
// to a sticky TRAP state with illegal=1; otherwise they act as a NOP.
module mips_mc_controller
    import mips_mc_pkg::*;
#(
    parameter int RESET_VEC_HOLD = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       illegal
);

    localparam logic [3:0] HOLD_LAST = 4'(RESET_VEC_HOLD - 1);

`ifdef MC_ILLEGAL_TRAP_EN
    localparam state_t ILLEGAL_NEXT = ST_TRAP;
`else
    localparam state_t ILLEGAL_NEXT = ST_FETCH;
`endif

    state_t     state;
    state_t     next_state;
    moore_t     outs;
    logic [3:0] hold_cnt;
    logic       funct_illegal;

    mips_mc_alu_dec u_alu_dec (
        .alu_cls       (state_alu_class(state)),
        .funct         (funct),
        .alu_op        (alu_op),
        .funct_illegal (funct_illegal)
    );

    // Next-state selection; opcode/funct are only looked at in the states that decode them
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:     next_state = (hold_cnt == HOLD_LAST) ? ST_FETCH : ST_IDLE;
            ST_FETCH:    next_state = mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (opcode)
                    OP_RTYPE:     next_state = ST_R_EXEC;
                    OP_LW, OP_SW: next_state = ST_MEM_ADDR;
                    OP_ADDI:      next_state = ST_I_EXEC;
                    OP_BEQ:       next_state = ST_BRANCH;
                    OP_J:         next_state = ST_JUMP;
                    default:      next_state = ILLEGAL_NEXT;
                endcase
            end
            ST_MEM_ADDR: next_state = (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD:   next_state = mem_ready ? ST_MEM_WB : ST_MEM_RD;
            ST_MEM_WB:   next_state = ST_FETCH;
            ST_MEM_WR:   next_state = mem_ready ? ST_FETCH : ST_MEM_WR;
            ST_R_EXEC:   next_state = funct_illegal ? ILLEGAL_NEXT : ST_R_WB;
            ST_R_WB:     next_state = ST_FETCH;
            ST_I_EXEC:   next_state = ST_I_WB;
            ST_I_WB:     next_state = ST_FETCH;
            ST_BRANCH:   next_state = ST_FETCH;
            ST_JUMP:     next_state = ST_FETCH;
            ST_TRAP:     next_state = ST_TRAP;
            default:     next_state = ST_IDLE;
        endcase
    end

    // State, reset hold counter and registered control word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            outs     <= '0;
            hold_cnt <= '0;
        end else begin
            state <= next_state;
            outs  <= moore_outputs(next_state);
            if (state == ST_IDLE && next_state == ST_IDLE) begin
                hold_cnt <= hold_cnt + 4'd1;
            end
        end
    end

`ifdef MC_ILLEGAL_TRAP_EN
    logic illegal_q;

    // Sticky illegal flag, set on entry to TRAP and only cleared by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= (next_state == ST_TRAP);
        end
    end

    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    assign mem_read      = outs.mem_read;
    assign mem_write     = outs.mem_write;
    assign iord          = outs.iord;
    assign ir_write      = outs.fetch & mem_ready;
    assign pc_write      = outs.pc_write | (outs.fetch & mem_ready);
    assign pc_write_cond = outs.branch & zero;
    assign pc_src        = outs.pc_src;
    assign alu_src_a     = outs.alu_src_a;
    assign alu_src_b     = outs.alu_src_b;
    assign reg_write     = outs.reg_write;
    assign reg_dst       = outs.reg_dst;
    assign mem_to_reg    = outs.mem_to_reg;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Testbench for mips_mc_controller: directed instruction scenarios followed
// by randomized instruction streams with random wait states, each checked
// cycle by cycle against an instruction-level expected control sequence.
module tb_mips_mc_controller;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       illegal;
    } ctrl_t;

    localparam int K_R     = 0;
    localparam int K_LW    = 1;
    localparam int K_SW    = 2;
    localparam int K_ADDI  = 3;
    localparam int K_BEQ   = 4;
    localparam int K_J     = 5;
    localparam int K_BADOP = 6;
    localparam int K_BADFN = 7;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       illegal;

    ctrl_t obs;
    int    vectors;
    int    miscompares;

    logic [5:0] legalFn [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h02};

    mips_mc_controller dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .funct         (funct),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .iord          (iord),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_src        (pc_src),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .illegal       (illegal)
    );

    assign obs = {mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond,
                  pc_src, alu_src_a, alu_src_b, alu_op,
                  reg_write, reg_dst, mem_to_reg, illegal};

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU code the instruction set assigns to each supported funct
    function automatic logic functOp(input logic [5:0] fn, output logic [2:0] aop);
        aop = 3'b000;
        case (fn)
            6'h20:   begin aop = 3'b000; return 1'b1; end
            6'h22:   begin aop = 3'b001; return 1'b1; end
            6'h24:   begin aop = 3'b010; return 1'b1; end
            6'h25:   begin aop = 3'b011; return 1'b1; end
            6'h2A:   begin aop = 3'b100; return 1'b1; end
            6'h02:   begin aop = 3'b101; return 1'b1; end
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic isKnownOp(input logic [5:0] op);
        return (op == 6'h00) || (op == 6'h23) || (op == 6'h2B) ||
               (op == 6'h08) || (op == 6'h04) || (op == 6'h02);
    endfunction

    function automatic logic [5:0] randomIllegalOp();
        logic [5:0] op;
        op = 6'($urandom);
        while (isKnownOp(op)) op = 6'($urandom);
        return op;
    endfunction

    function automatic logic [5:0] randomIllegalFn();
        logic [5:0] fn;
        logic [2:0] dummy;
        fn = 6'($urandom);
        while (functOp(fn, dummy)) fn = 6'($urandom);
        return fn;
    endfunction

    task automatic applyStimulus(input logic rdy, input logic z,
                                 input logic [5:0] op, input logic [5:0] fn);
        mem_ready = rdy;
        zero      = z;
        opcode    = op;
        funct     = fn;
    endtask

    task automatic checkOutput(input string tag, input ctrl_t expected);
        vectors++;
        assert (obs === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%05h expected=%05h", tag, obs, expected);
        end
    endtask

    // One clock cycle: drive just after the edge, compare at the falling edge
    task automatic step(input logic rdy, input logic z, input logic [5:0] op,
                        input logic [5:0] fn, input ctrl_t e, input string tag);
        applyStimulus(rdy, z, op, fn);
        @(negedge clk);
        checkOutput(tag, e);
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset from mid-cycle, then the single IDLE cycle
    task automatic doReset(input string tag);
        rst_n = 1'b0;
        #1;
        checkOutput(tag, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'($urandom), 1'($urandom), 6'($urandom), 6'($urandom), '0, "idle");
    endtask

    task automatic illegalTail();
`ifdef MC_ILLEGAL_TRAP_EN
        ctrl_t e;
        for (int i = 0; i < 3; i++) begin
            e = '0;
            e.illegal = 1'b1;
            step(1'($urandom), 1'($urandom), 6'($urandom), 6'($urandom), e, "trap_hold");
        end
        doReset("trap_reset");
`endif
    endtask

    // Expected control sequence of one instruction, derived from its class
    task automatic runInstr(input int kind, input logic [5:0] fn, input int fwait,
                            input int mwait, input logic z, input logic [5:0] badOp);
        logic [5:0] op;
        logic [2:0] aop;
        logic       fnOk;
        ctrl_t      e;
        case (kind)
            K_R, K_BADFN: op = 6'h00;
            K_LW:         op = 6'h23;
            K_SW:         op = 6'h2B;
            K_ADDI:       op = 6'h08;
            K_BEQ:        op = 6'h04;
            K_J:          op = 6'h02;
            default:      op = badOp;
        endcase

        for (int i = 0; i <= fwait; i++) begin
            e = '0;
            e.mem_read  = 1'b1;
            e.alu_src_b = 2'b01;
            if (i == fwait) begin
                e.ir_write = 1'b1;
                e.pc_write = 1'b1;
            end
            step(i == fwait, 1'($urandom), 6'($urandom), 6'($urandom), e, "fetch");
        end

        e = '0;
        e.alu_src_b = 2'b11;
        step(1'($urandom), 1'($urandom), op, fn, e, "decode");

        case (kind)
            K_R, K_BADFN: begin
                fnOk = functOp(fn, aop);
                e = '0;
                e.alu_src_a = 1'b1;
                e.alu_op    = fnOk ? aop : 3'b000;
                step(1'($urandom), 1'($urandom), op, fn, e, "r_exec");
                if (fnOk) begin
                    e = '0;
                    e.reg_write = 1'b1;
                    e.reg_dst   = 1'b1;
                    step(1'($urandom), 1'($urandom), op, fn, e, "r_wb");
                end else begin
                    illegalTail();
                end
            end
            K_LW, K_SW: begin
                e = '0;
                e.alu_src_a = 1'b1;
                e.alu_src_b = 2'b10;
                step(1'($urandom), 1'($urandom), op, fn, e, "mem_addr");
                for (int i = 0; i <= mwait; i++) begin
                    e = '0;
                    e.iord = 1'b1;
                    if (kind == K_LW) e.mem_read = 1'b1;
                    else              e.mem_write = 1'b1;
                    step(i == mwait, 1'($urandom), op, fn, e, "mem_access");
                end
                if (kind == K_LW) begin
                    e = '0;
                    e.reg_write  = 1'b1;
                    e.mem_to_reg = 1'b1;
                    step(1'($urandom), 1'($urandom), op, fn, e, "mem_wb");
                end
            end
            K_ADDI: begin
                e = '0;
                e.alu_src_a = 1'b1;
                e.alu_src_b = 2'b10;
                step(1'($urandom), 1'($urandom), op, fn, e, "i_exec");
                e = '0;
                e.reg_write = 1'b1;
                step(1'($urandom), 1'($urandom), op, fn, e, "i_wb");
            end
            K_BEQ: begin
                e = '0;
                e.alu_src_a     = 1'b1;
                e.alu_op        = 3'b001;
                e.pc_src        = 2'b01;
                e.pc_write_cond = z;
                step(1'($urandom), z, op, fn, e, "branch");
            end
            K_J: begin
                e = '0;
                e.pc_write = 1'b1;
                e.pc_src   = 2'b10;
                step(1'($urandom), 1'($urandom), op, fn, e, "jump");
            end
            default: illegalTail();
        endcase
    endtask

    initial begin
        int    kind;
        ctrl_t e;
        logic [5:0] fn;

        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        applyStimulus(1'b0, 1'b0, 6'h00, 6'h00);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_state", '0);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 6'h00, 6'h00, '0, "idle");

        $display("[TB] directed scenarios");
        runInstr(K_R, 6'h2A, 0, 0, 1'b0, 6'h00);
        runInstr(K_LW, 6'h00, 0, 2, 1'b0, 6'h00);
        runInstr(K_BEQ, 6'h00, 0, 0, 1'b1, 6'h00);
        runInstr(K_BEQ, 6'h00, 0, 0, 1'b0, 6'h00);
        runInstr(K_BADOP, 6'h00, 0, 0, 1'b0, 6'h3F);
        runInstr(K_J, 6'h00, 1, 0, 1'b0, 6'h00);

        $display("[TB] random instruction stream");
        for (int n = 0; n < 150; n++) begin
            kind = $urandom_range(0, 7);
            if (kind == K_BADFN) fn = randomIllegalFn();
            else                 fn = legalFn[$urandom_range(0, 5)];
            runInstr(kind, fn, $urandom_range(0, 2), $urandom_range(0, 2),
                     1'($urandom), randomIllegalOp());
        end

        $display("[TB] reset during store access");
        e = '0;
        e.mem_read = 1'b1; e.alu_src_b = 2'b01; e.ir_write = 1'b1; e.pc_write = 1'b1;
        step(1'b1, 1'b0, 6'h00, 6'h00, e, "fetch");
        e = '0;
        e.alu_src_b = 2'b11;
        step(1'b0, 1'b0, 6'h2B, 6'h00, e, "decode");
        e = '0;
        e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
        step(1'b0, 1'b0, 6'h2B, 6'h00, e, "mem_addr");
        applyStimulus(1'b0, 1'b0, 6'h2B, 6'h00);
        @(negedge clk);
        e = '0;
        e.mem_write = 1'b1; e.iord = 1'b1;
        checkOutput("mem_wr_pre", e);
        #2;
        doReset("async_reset");
        runInstr(K_J, 6'h00, 0, 0, 1'b0, 6'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
